// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//   Counting core of the timer. Takes the register block's control outputs,
//   runs a 64-bit up-counter behind an optional power-of-two prescaler, and
//   raises a sticky compare-match interrupt.
//
// Parameters
//   DIV_MAX            max divider exponent; prescaler is DIV_MAX bits wide
//
// Ports
//   sys_clk            in   1   system clock, rising edge
//   sys_rst_n          in   1   synchronous active-low reset
//   timer_en           in   1   counter runs when 1
//   div_en             in   1   1: count once per 2**d cycles, 0: every cycle
//   div_val            in   4   divider exponent, saturated at DIV_MAX
//   halt_req           in   1   debug halt request
//   dbg_mode           in   1   halt honoured only when 1
//   counter_clear      in   1   pulse: zero counter and prescaler
//   counter_write_sel  in   2   01: load low word, 10: load high word
//   counter_write_data in   32  load data
//   compare_val        in   64  compare value
//   interrupt_en       in   1   interrupt output mask
//   interrupt_clear    in   1   pulse: clear interrupt_status
//   cnt_val            out  64  counter value (registered)
//   halt_ack_status    out  1   counter frozen by halt (registered)
//   interrupt_status   out  1   sticky compare-match flag (registered)
//   tim_int            out  1   interrupt_status & interrupt_en
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter int DIV_MAX = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        timer_en,
    input  logic        div_en,
    input  logic [3:0]  div_val,
    input  logic        halt_req,
    input  logic        dbg_mode,
    input  logic        counter_clear,
    input  logic [1:0]  counter_write_sel,
    input  logic [31:0] counter_write_data,
    input  logic [63:0] compare_val,
    input  logic        interrupt_en,
    input  logic        interrupt_clear,
    output logic [63:0] cnt_val,
    output logic        halt_ack_status,
    output logic        interrupt_status,
    output logic        tim_int
);

    logic [DIV_MAX-1:0] prescaler;
    logic [DIV_MAX-1:0] presc_limit;
    logic [31:0]        div_eff;
    logic               tick;

    // Effective exponent d = min(div_val, DIV_MAX); the terminal count
    // 2**d - 1 is simply the low d bits set, which avoids any shift.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        div_eff     = {28'd0, div_val};
        presc_limit = '0;
        if (div_eff > 32'(DIV_MAX)) begin
            div_eff = 32'(DIV_MAX);
        end
        for (int i = 0; i < DIV_MAX; i++) begin
            presc_limit[i] = (32'(i) < div_eff);
        end
        tick = !div_en || (prescaler == presc_limit);
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // right-hand side sees pre-edge values, independent of statement order.
        if (!sys_rst_n) begin
            prescaler        <= '0;
            cnt_val          <= '0;
            halt_ack_status  <= 1'b0;
            interrupt_status <= 1'b0;
        end else begin
            halt_ack_status <= halt_req & dbg_mode;

            // A limit lowered below the current prescaler value makes the
            // ">=" branch fire: wrap to 0 without producing a tick.
            if (counter_clear || !timer_en || !div_en) begin
                prescaler <= '0;
            end else if (!halt_ack_status) begin
                prescaler <= (prescaler >= presc_limit) ? '0
                                                        : prescaler + DIV_MAX'(1);
            end

            if (counter_clear) begin
                cnt_val <= '0;
            end else if (counter_write_sel == 2'b01) begin
                cnt_val[31:0] <= counter_write_data;
            end else if (counter_write_sel == 2'b10) begin
                cnt_val[63:32] <= counter_write_data;
            end else if (timer_en && tick && !halt_ack_status) begin
                cnt_val <= cnt_val + 64'd1;
            end

            // Set has priority over clear.
            if (cnt_val == compare_val) begin
                interrupt_status <= 1'b1;
            end else if (interrupt_clear) begin
                interrupt_status <= 1'b0;
            end
        end
    end

    assign tim_int = interrupt_status & interrupt_en;

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//   Self-checking bench for timer_counter: directed scenarios followed by a
//   randomized phase, all compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_timer_counter;

    localparam int DIV_MAX = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        timer_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic        halt_req;
    logic        dbg_mode;
    logic        counter_clear;
    logic [1:0]  counter_write_sel;
    logic [31:0] counter_write_data;
    logic [63:0] compare_val;
    logic        interrupt_en;
    logic        interrupt_clear;
    logic [63:0] cnt_val;
    logic        halt_ack_status;
    logic        interrupt_status;
    logic        tim_int;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [63:0] m_cnt   = '0;
    int          m_presc = 0;
    bit          m_halt  = 1'b0;
    bit          m_int   = 1'b0;

    timer_counter #(.DIV_MAX(DIV_MAX)) dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .timer_en           (timer_en),
        .div_en             (div_en),
        .div_val            (div_val),
        .halt_req           (halt_req),
        .dbg_mode           (dbg_mode),
        .counter_clear      (counter_clear),
        .counter_write_sel  (counter_write_sel),
        .counter_write_data (counter_write_data),
        .compare_val        (compare_val),
        .interrupt_en       (interrupt_en),
        .interrupt_clear    (interrupt_clear),
        .cnt_val            (cnt_val),
        .halt_ack_status    (halt_ack_status),
        .interrupt_status   (interrupt_status),
        .tim_int            (tim_int)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference: the divider period is 2**d cycles,
    // the counter follows the clear > write > count priority.
    task automatic model_step();
        int d;
        int period;
        bit tk;
        bit match;
        d      = (int'(div_val) > DIV_MAX) ? DIV_MAX : int'(div_val);
        period = 1 << d;
        match  = (m_cnt == compare_val);
        tk     = !div_en || (m_presc == period - 1);
        if (!sys_rst_n) begin
            m_cnt = '0; m_presc = 0; m_halt = 1'b0; m_int = 1'b0;
        end else begin
            if (counter_clear)                 m_cnt = '0;
            else if (counter_write_sel == 2'd1) m_cnt = {m_cnt[63:32], counter_write_data};
            else if (counter_write_sel == 2'd2) m_cnt = {counter_write_data, m_cnt[31:0]};
            else if (timer_en && tk && !m_halt) m_cnt = m_cnt + 64'd1;

            if (counter_clear || !timer_en || !div_en) m_presc = 0;
            else if (!m_halt) m_presc = (m_presc >= period) ? 0 : (m_presc + 1) % period;

            m_halt = halt_req && dbg_mode;
            if (match)                m_int = 1'b1;
            else if (interrupt_clear) m_int = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge sys_clk);
        model_step();
        #1;
        check("cnt_val", cnt_val, m_cnt);
        check("halt_ack", 64'(halt_ack_status), 64'(m_halt));
        check("int_status", 64'(interrupt_status), 64'(m_int));
        check("tim_int", 64'(tim_int), 64'(m_int && interrupt_en));
    endtask

    initial begin
        sys_rst_n = 1'b0; timer_en = 1'b0; div_en = 1'b0; div_val = '0;
        halt_req = 1'b0; dbg_mode = 1'b0; counter_clear = 1'b0;
        counter_write_sel = '0; counter_write_data = '0;
        compare_val = 64'hA5A5_A5A5_0000_0000;
        interrupt_en = 1'b0; interrupt_clear = 1'b0;
        cycle();
        check("reset_cnt", cnt_val, 64'd0);

        // Reset mid-count with halt and interrupt both active
        sys_rst_n = 1'b1; counter_write_sel = 2'b01; counter_write_data = 32'h1234;
        compare_val = 64'h1234; halt_req = 1'b1; dbg_mode = 1'b1;
        cycle();
        counter_write_sel = '0;
        cycle();
        check("pre_rst_cnt", cnt_val, 64'h1234);
        check("pre_rst_int", 64'(interrupt_status), 64'd1);
        check("pre_rst_halt", 64'(halt_ack_status), 64'd1);
        timer_en = 1'b1; sys_rst_n = 1'b0;
        cycle();
        check("rst_cnt", cnt_val, 64'd0);
        check("rst_halt", 64'(halt_ack_status), 64'd0);
        check("rst_int", 64'(interrupt_status), 64'd0);
        sys_rst_n = 1'b1; halt_req = 1'b0; compare_val = 64'hA5A5_A5A5_0000_0000;

        // Undivided, then divide-by-4
        repeat (10) cycle();
        check("nodiv_10", cnt_val, 64'd10);
        div_en = 1'b1; div_val = 4'd2;
        repeat (16) cycle();
        check("div4_16", cnt_val, 64'd14);

        // div_val above DIV_MAX saturates at 2**DIV_MAX
        div_val = 4'd12; counter_clear = 1'b1;
        cycle();
        counter_clear = 1'b0;
        repeat (255) cycle();
        check("div_sat_255", cnt_val, 64'd0);
        cycle();
        check("div_sat_256", cnt_val, 64'd1);

        // 64-bit wrap via word writes
        timer_en = 1'b0; div_en = 1'b0;
        counter_write_sel = 2'b01; counter_write_data = 32'hFFFF_FFFE;
        cycle();
        counter_write_sel = 2'b10; counter_write_data = 32'hFFFF_FFFF;
        cycle();
        counter_write_sel = '0;
        check("write_words", cnt_val, 64'hFFFF_FFFF_FFFF_FFFE);
        timer_en = 1'b1;
        cycle();
        check("wrap_all_ones", cnt_val, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        check("wrap_zero", cnt_val, 64'd0);

        // Compare / interrupt
        timer_en = 1'b0; counter_clear = 1'b1; interrupt_clear = 1'b1;
        compare_val = 64'd5; interrupt_en = 1'b1;
        cycle();
        counter_clear = 1'b0; interrupt_clear = 1'b0; timer_en = 1'b1;
        repeat (5) cycle();
        check("cmp_cnt5", cnt_val, 64'd5);
        check("cmp_int_before", 64'(interrupt_status), 64'd0);
        timer_en = 1'b0;
        cycle();
        check("cmp_int_set", 64'(interrupt_status), 64'd1);
        check("cmp_tim_int", 64'(tim_int), 64'd1);
        cycle();
        interrupt_clear = 1'b1;
        cycle();
        check("clr_vs_match", 64'(interrupt_status), 64'd1);
        interrupt_clear = 1'b0; compare_val = 64'd100;
        cycle();
        check("int_sticky", 64'(interrupt_status), 64'd1);
        interrupt_en = 1'b0;
        #1;
        check("tim_int_masked", 64'(tim_int), 64'd0);
        interrupt_clear = 1'b1;
        cycle();
        check("int_cleared", 64'(interrupt_status), 64'd0);
        interrupt_clear = 1'b0; interrupt_en = 1'b1;

        // Halt honoured in debug mode, write still lands while halted
        compare_val = 64'hA5A5_A5A5_0000_0000; counter_clear = 1'b1;
        cycle();
        counter_clear = 1'b0; timer_en = 1'b1; halt_req = 1'b1; dbg_mode = 1'b1;
        cycle();
        check("halt_ack_lag", 64'(halt_ack_status), 64'd1);
        check("halt_req_cycle", cnt_val, 64'd1);
        repeat (3) cycle();
        check("halt_frozen", cnt_val, 64'd1);
        counter_write_sel = 2'b01; counter_write_data = 32'h50;
        cycle();
        check("halt_write", cnt_val, 64'h50);
        counter_write_sel = '0; dbg_mode = 1'b0;
        cycle();
        check("nodbg_ack", 64'(halt_ack_status), 64'd0);
        cycle();
        check("nodbg_runs", cnt_val, 64'h51);
        halt_req = 1'b0;

        // Clear beats write and tick; prescaler restarts from 0
        div_en = 1'b1; div_val = 4'd3; counter_clear = 1'b1;
        cycle();
        counter_clear = 1'b0;
        for (int i = 0; i < 16 && m_presc != 7; i++) cycle();
        counter_clear = 1'b1; counter_write_sel = 2'b01; counter_write_data = 32'hFFFF;
        cycle();
        check("clr_prio", cnt_val, 64'd0);
        counter_clear = 1'b0; counter_write_sel = '0;
        repeat (7) cycle();
        check("clr_presc_7", cnt_val, 64'd0);
        cycle();
        check("clr_presc_8", cnt_val, 64'd1);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            sys_rst_n       = ($urandom_range(0, 299) != 0);
            timer_en        = ($urandom_range(0, 9) != 0);
            counter_clear   = ($urandom_range(0, 99) == 0);
            interrupt_clear = ($urandom_range(0, 19) == 0);
            counter_write_data = $urandom;
            counter_write_sel  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if ($urandom_range(0, 39) == 0) begin
                div_en  = 1'($urandom_range(0, 1));
                div_val = 4'($urandom_range(0, 15));
                if (div_val > 4'd4 && $urandom_range(0, 1) == 1) div_val = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
            if ($urandom_range(0, 31) == 0) dbg_mode = ~dbg_mode;
            if ($urandom_range(0, 31) == 0) interrupt_en = ~interrupt_en;
            if ($urandom_range(0, 29) == 0) compare_val = m_cnt + 64'($urandom_range(0, 20));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
